s2p_frame_ctrl: RTL



---
 rtl/s2p_pkg.sv | 17 +
 rtl/s2p_frame_ctrl_if.sv | 24 ++
 rtl/s2p_shift_core.sv | 42 ++++
 rtl/s2p_frame_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/s2p_pkg.sv
// Shared types and counter-width helpers for the serial-to-parallel framing controller.
package s2p_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int bit_cnt_w(input int data_width);
    return (data_width > 1) ? $clog2(data_width) : 1;
  endfunction

  function automatic int word_cnt_w(input int frame_words);
    return (frame_words > 1) ? $clog2(frame_words) : 1;
  endfunction

endpackage

// File: rtl/s2p_frame_ctrl_if.sv
// Serial input bundle plus valid/ready word output; slave is the controller's view.
interface s2p_frame_ctrl_if #(
  parameter int DATA_WIDTH = 16
);

  logic                  din;
  logic                  din_valid;
  logic                  sof;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output din, din_valid, sof, out_ready,
    input  out_data, out_valid, out_last
  );

  modport slave (
    input  din, din_valid, sof, out_ready,
    output out_data, out_valid, out_last
  );

endinterface

// File: rtl/s2p_shift_core.sv
// LSB-in shift register with bit counter; flags the bit that completes a word.
module s2p_shift_core
  import s2p_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_din,
  input  logic                  i_shift_en,
  input  logic                  i_restart,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic                  o_word_done
);

  localparam int             BCW      = bit_cnt_w(DATA_WIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  // The oldest bit is never observable: a word is always read as {shreg, din}.
  logic [DATA_WIDTH-2:0] r_shreg;
  logic [BCW-1:0]        r_bit_cnt;

  assign o_word      = {r_shreg, i_din};
  assign o_word_done = i_shift_en & ~i_restart & (r_bit_cnt == LAST_BIT);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end else if (i_shift_en) begin
      r_shreg <= o_word[DATA_WIDTH-2:0];
      if (i_restart) begin
        r_bit_cnt <= BCW'(1);
      end else if (o_word_done) begin
        r_bit_cnt <= '0;
      end else begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/s2p_frame_ctrl.sv
// Frames a qualified serial stream into FRAME_WORDS words of DATA_WIDTH bits each.
// Words appear on the edge of their last bit; a word completing while the output is stalled is dropped.
module s2p_frame_ctrl
  import s2p_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAME_WORDS = 4
) (
  input  logic               clk,
  input  logic               resetn,
  s2p_frame_ctrl_if.slave    bus,
  output logic               busy,
  output logic               overflow,
  output logic               sync_err,
  input  logic               clr_flags
);

  localparam int             WCW       = word_cnt_w(FRAME_WORDS);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(FRAME_WORDS - 1);

  state_t                r_state;
  logic [WCW-1:0]        r_word_cnt;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic                  r_busy;
  logic                  r_overflow;
  logic                  r_sync_err;

  logic                  w_sof;
  logic                  w_shift_en;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_word_done;
  logic                  w_last_word;
  logic                  w_can_load;
  logic                  w_ovf_set;
  logic                  w_serr_set;

  assign w_sof       = bus.din_valid & bus.sof;
  // Outside a frame only a start marker is allowed into the shifter.
  assign w_shift_en  = bus.din_valid & (bus.sof | (r_state == SHIFT));
  assign w_last_word = (r_word_cnt == LAST_WORD);
  assign w_can_load  = ~r_out_valid | bus.out_ready;
  assign w_ovf_set   = w_word_done & ~w_can_load;
  assign w_serr_set  = w_sof & (r_state == SHIFT);

  s2p_shift_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shift_core (
    .clk         (clk),
    .resetn      (resetn),
    .i_din       (bus.din),
    .i_shift_en  (w_shift_en),
    .i_restart   (w_sof),
    .o_word      (w_word),
    .o_word_done (w_word_done)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_word_cnt <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_sof) begin
            r_state    <= SHIFT;
            r_busy     <= 1'b1;
            r_word_cnt <= '0;
          end
        end
        SHIFT: begin
          if (w_sof) begin
            r_word_cnt <= '0;
          end else if (w_word_done) begin
            if (w_last_word) begin
              r_word_cnt <= '0;
              r_state    <= IDLE;
              r_busy     <= 1'b0;
            end else begin
              r_word_cnt <= r_word_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_word_done && w_can_load) begin
      r_out_data  <= w_word;
      r_out_last  <= w_last_word;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Set has priority over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_overflow <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_overflow <= (r_overflow & ~clr_flags) | w_ovf_set;
      r_sync_err <= (r_sync_err & ~clr_flags) | w_serr_set;
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign busy          = r_busy;
  assign overflow      = r_overflow;
  assign sync_err      = r_sync_err;

endmodule
